decode_stage_idex: RTL
======================

Name: decode_stage_idex

Overview:
Parametrised successor to the ID-stage decoder for the 5-stage RV64 pipeline.
- Decodes the IF/ID instruction and reads the internal 32-entry register file, with optional write-through bypass.
- Generates I/S/B/U/J immediates.
- Detects load-use hazards against its own ID/EX contents and inserts bubbles autonomously.
- Registers all results into an ID/EX pipeline register with valid, stall and flush handling.

Parameters:
XLEN, 64, datapath and register width (32 or 64 supported).
WB_BYPASS, 1, 1 = same-cycle write-back data forwarded to the read ports; 0 = raw register-file read.
ZERO_ON_BUBBLE, 1, 1 = bubble clears all ID/EX data fields; 0 = clears only valid and control bits.

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high; one clock; sampled on the rising edge of clk
if_valid  in  1  IF/ID register holds a real instruction
instruction  in  32  IF/ID instruction
if_pc  in  XLEN  IF/ID program counter
flush  in  1  taken branch/jump; kill the instruction entering ID/EX
wb_regwrite  in  1  write-back enable
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back data
stall  out  1  combinational; hold PC and IF/ID this cycle
idex_valid  out  1  ID/EX holds a real instruction
idex_pc, idex_rs1_data, idex_rs2_data, idex_imm  out  XLEN each  registered operands
idex_rd, idex_rs1, idex_rs2  out  5 each  registered register indices
idex_funct3  out  3  registered
idex_funct7  out  7  registered
idex_branch, idex_jump, idex_memread, idex_memtoreg, idex_memwrite, idex_alusrc, idex_regwrite, idex_illegal  out  1 each  registered controls
idex_aluop  out  2  registered

Behaviour:
- Register file:
  - Write on clk edge when wb_regwrite and wb_rd!=0.
  - x0 always reads 0.
  - reset clears all 32 entries.
- Write-back bypass (WB_BYPASS=1): if wb_regwrite && wb_rd!=0 && wb_rd==rs, the read returns wb_data in the same cycle.
- Decode (opcode -> branch, jump, memread, memtoreg, memwrite, alusrc, regwrite, aluop):
  - R 0110011: 0,0,0,0,0,0,1,10
  - I-ALU 0010011: 0,0,0,0,0,1,1,11
  - LOAD 0000011: 0,0,1,1,0,1,1,00
  - STORE 0100011: 0,0,0,0,1,1,0,00
  - BRANCH 1100011: 1,0,0,0,0,0,0,01
  - JAL 1101111: 0,1,0,0,0,0,1,00
  - JALR 1100111: 0,1,0,0,0,1,1,00
  - LUI 0110111: 0,0,0,0,0,1,1,00
  - Any other opcode: all controls 0, illegal=1.
- Immediates, sign-extended from instruction[31] to XLEN:
  - I: [31:20]
  - S: [31:25|11:7]
  - B: [31|7|30:25|11:8|0]
  - U: [31:12]<<12
  - J: [31|19:12|20|30:21|0]
  - R-type: 0
- Source usage:
  - uses_rs1 = every opcode except JAL, LUI and illegal.
  - uses_rs2 = R, STORE, BRANCH.
- Load-use hazard:
  - hazard = if_valid && idex_valid && idex_memread && idex_rd!=0 && ((uses_rs1 && idex_rd==rs1) || (uses_rs2 && idex_rd==rs2)).
  - stall = hazard && !flush.
- ID/EX update on each clk edge, priority reset > flush > hazard > normal:
  - reset: every idex_* output = 0.
  - flush: idex_valid and all controls = 0; data fields cleared when ZERO_ON_BUBBLE=1, else retain decoded values.
  - hazard: bubble inserted; same clearing rule as flush. The IF/ID instruction is presented again next cycle; the bubble clears idex_memread, so the stall lasts exactly 1 cycle.
  - !if_valid: treated as a bubble; stall=0.
  - normal: idex_valid=1; all fields are loaded from the decode and the register-file read.
- Latency: 1 cycle from instruction to idex_*.
- Reset:
  - All outputs 0 on the first edge with reset=1; stall=0 while reset is high.
  - Reset mid-stall discards the pending hazard.
- Simultaneous events:
  - Write-back to rs in the same cycle as decode: bypass delivers the new value (WB_BYPASS=1).
  - flush and hazard together: flush wins; stall=0.
- XLEN=32: immediates are truncated to 32 bits; register-file entries are 32 bits.

Test Plan:
- Reset: assert reset 1 cycle with an R-type on instruction -> every idex_* output 0 and stall 0; then ADD x3,x1,x2 (0x002081B3) -> next cycle idex_regwrite=1, idex_aluop=10, idex_rd=3, idex_valid=1.
- Immediates:
  - LW x5,-8(x2) (0xFF812283) -> idex_imm=0xFFFFFFFFFFFFFFF8, memread=1, memtoreg=1.
  - BEQ x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFFFFFFFFFC, branch=1, aluop=01.
- Load-use: LW x5,0(x2) followed by ADD x6,x5,x1 -> stall=1 for exactly 1 cycle, bubble with idex_valid=0; the ADD issues on the following cycle. Follow with ADDI x6,x0,1 after the LW -> stall=0.
- Write-back bypass: wb_regwrite=1, wb_rd=1, wb_data=0x1234 in the same cycle as decoding ADD x3,x1,x0 -> idex_rs1_data=0x1234. Repeat with wb_rd=0 -> x0 reads 0 and the register file is unchanged.
- Flush versus hazard: drive flush=1 during the LW/ADD hazard -> stall=0, idex_valid=0, all controls 0.
- Illegal opcode: instruction 0x0000007F -> idex_illegal=1, all other controls 0, idex_valid=1. Then JAL x1,+16 (0x010000EF) -> jump=1, regwrite=1, imm=16.

Source files
------------

// File: rtl/decode_stage_idex.sv
// ID stage for the 5-stage RV64 pipeline: decode, register-file read with optional
// write-back bypass, immediate generation, load-use bubble insertion and the ID/EX register.
module decode_stage_idex #(
  parameter int XLEN           = 64,
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_rs1_data,
  output logic [XLEN-1:0] idex_rs2_data,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rd,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [2:0]      idex_funct3,
  output logic [6:0]      idex_funct7,
  output logic            idex_branch,
  output logic            idex_jump,
  output logic            idex_memread,
  output logic            idex_memtoreg,
  output logic            idex_memwrite,
  output logic            idex_alusrc,
  output logic            idex_regwrite,
  output logic            idex_illegal,
  output logic [1:0]      idex_aluop
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  logic [XLEN-1:0] r_regs [32];

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  logic [63:0]     w_imm64;
  logic [XLEN-1:0] w_imm;
  logic            w_branch, w_jump, w_memread, w_memtoreg, w_memwrite;
  logic            w_alusrc, w_regwrite, w_illegal;
  logic [1:0]      w_aluop;
  logic            w_uses_rs1, w_uses_rs2;
  logic            w_hazard, w_bubble, w_clear_data;

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_regwrite && (wb_rd != 5'd0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (WB_BYPASS && wb_regwrite && (wb_rd != 5'd0)) begin
      if (wb_rd == w_rs1) w_rs1_data = wb_data;
      if (wb_rd == w_rs2) w_rs2_data = wb_data;
    end
    if (w_rs1 == 5'd0) w_rs1_data = '0;
    if (w_rs2 == 5'd0) w_rs2_data = '0;
  end

  always_comb begin
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_memread  = 1'b0;
    w_memtoreg = 1'b0;
    w_memwrite = 1'b0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    w_aluop    = 2'b00;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_imm64    = '0;
    unique case (w_opcode)
      OP_R: begin
        w_regwrite = 1'b1; w_aluop = 2'b10;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        w_alusrc = 1'b1; w_regwrite = 1'b1; w_aluop = 2'b11;
        w_uses_rs1 = 1'b1;
        w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
      end
      OP_LOAD: begin
        w_memread = 1'b1; w_memtoreg = 1'b1; w_alusrc = 1'b1; w_regwrite = 1'b1;
        w_uses_rs1 = 1'b1;
        w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
      end
      OP_STORE: begin
        w_memwrite = 1'b1; w_alusrc = 1'b1;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_imm64 = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BRANCH: begin
        w_branch = 1'b1; w_aluop = 2'b01;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
        w_imm64 = {{52{instruction[31]}}, instruction[7], instruction[30:25],
                   instruction[11:8], 1'b0};
      end
      OP_JAL: begin
        w_jump = 1'b1; w_regwrite = 1'b1;
        w_imm64 = {{44{instruction[31]}}, instruction[19:12], instruction[20],
                   instruction[30:21], 1'b0};
      end
      OP_JALR: begin
        w_jump = 1'b1; w_alusrc = 1'b1; w_regwrite = 1'b1;
        w_uses_rs1 = 1'b1;
        w_imm64 = {{52{instruction[31]}}, instruction[31:20]};
      end
      OP_LUI: begin
        w_alusrc = 1'b1; w_regwrite = 1'b1;
        w_imm64 = {{32{instruction[31]}}, instruction[31:12], 12'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Narrower datapaths simply keep the low XLEN bits of the sign-extended immediate.
  assign w_imm = w_imm64[XLEN-1:0];

  assign w_hazard = if_valid && idex_valid && idex_memread && (idex_rd != 5'd0) &&
                    ((w_uses_rs1 && (idex_rd == w_rs1)) || (w_uses_rs2 && (idex_rd == w_rs2)));
  assign stall    = w_hazard && !flush && !reset;

  assign w_bubble     = flush || w_hazard || !if_valid;
  assign w_clear_data = reset || (w_bubble && ZERO_ON_BUBBLE);

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      idex_valid    <= 1'b0;
      idex_branch   <= 1'b0;
      idex_jump     <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memtoreg <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_alusrc   <= 1'b0;
      idex_regwrite <= 1'b0;
      idex_illegal  <= 1'b0;
      idex_aluop    <= 2'b00;
    end else begin
      idex_valid    <= 1'b1;
      idex_branch   <= w_branch;
      idex_jump     <= w_jump;
      idex_memread  <= w_memread;
      idex_memtoreg <= w_memtoreg;
      idex_memwrite <= w_memwrite;
      idex_alusrc   <= w_alusrc;
      idex_regwrite <= w_regwrite;
      idex_illegal  <= w_illegal;
      idex_aluop    <= w_aluop;
    end
  end

  // Data fields follow the decode unless reset or a zeroing bubble clears them.
  always_ff @(posedge clk) begin
    if (w_clear_data) begin
      idex_pc       <= '0;
      idex_rs1_data <= '0;
      idex_rs2_data <= '0;
      idex_imm      <= '0;
      idex_rd       <= '0;
      idex_rs1      <= '0;
      idex_rs2      <= '0;
      idex_funct3   <= '0;
      idex_funct7   <= '0;
    end else begin
      idex_pc       <= if_pc;
      idex_rs1_data <= w_rs1_data;
      idex_rs2_data <= w_rs2_data;
      idex_imm      <= w_imm;
      idex_rd       <= w_rd;
      idex_rs1      <= w_rs1;
      idex_rs2      <= w_rs2;
      idex_funct3   <= instruction[14:12];
      idex_funct7   <= instruction[31:25];
    end
  end

endmodule
